// File: rtl/muldiv_unit_if.sv
// Execute-stage <-> multiply/divide unit handshake: request, operands, status and result.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            StartE;
  logic [2:0]      MulDivFuncE;
  logic [XLEN-1:0] OpA;
  logic [XLEN-1:0] OpB;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  modport master (
    output StartE, MulDivFuncE, OpA, OpB,
    input  Busy, Done, Result
  );

  modport slave (
    input  StartE, MulDivFuncE, OpA, OpB,
    output Busy, Done, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up on completion and single-cycle divide-by-zero/overflow.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  localparam int unsigned CNT_W = 5;
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      func;
  logic            neg_res;
  logic            neg_rem;
  // hi/lo: partial product + multiplier for MUL*, remainder + dividend/quotient for DIV*
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opnd;

  // Request decode on the live bus inputs, used only on the accept edge
  logic            req_div_c;
  logic            a_neg_c;
  logic            b_neg_c;
  logic            div_zero_c;
  logic            div_ovf_c;
  logic [XLEN-1:0] mag_a_c;
  logic [XLEN-1:0] mag_b_c;

  always_comb begin
    req_div_c  = bus.MulDivFuncE[2];
    a_neg_c    = bus.OpA[XLEN-1] &&
                 (req_div_c ? !bus.MulDivFuncE[0] : (bus.MulDivFuncE[1:0] != 2'b11));
    b_neg_c    = bus.OpB[XLEN-1] &&
                 (req_div_c ? !bus.MulDivFuncE[0] : !bus.MulDivFuncE[1]);
    mag_a_c    = a_neg_c ? -bus.OpA : bus.OpA;
    mag_b_c    = b_neg_c ? -bus.OpB : bus.OpB;
    div_zero_c = req_div_c && (bus.OpB == '0);
    div_ovf_c  = req_div_c && !bus.MulDivFuncE[0] && (bus.OpA == MIN_NEG) && (bus.OpB == '1);
  end

  // One iteration of the shared shift-add / restoring-divide datapath, plus final result select
  logic [XLEN:0]   mul_sum_c;
  logic [XLEN:0]   div_sh_c;
  logic            div_ok_c;
  logic [XLEN-1:0] hi_n_c;
  logic [XLEN-1:0] lo_n_c;
  logic [PW-1:0]   prod_c;
  logic [XLEN-1:0] quot_c;
  logic [XLEN-1:0] rem_c;
  logic [XLEN-1:0] result_c;

  always_comb begin
    mul_sum_c = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_sh_c  = {hi, lo[XLEN-1]};
    div_ok_c  = (div_sh_c >= {1'b0, opnd});
    if (func[2]) begin
      hi_n_c = div_ok_c ? (div_sh_c[XLEN-1:0] - opnd) : div_sh_c[XLEN-1:0];
      lo_n_c = {lo[XLEN-2:0], div_ok_c};
    end else begin
      hi_n_c = mul_sum_c[XLEN:1];
      lo_n_c = {mul_sum_c[0], lo[XLEN-1:1]};
    end
    prod_c = neg_res ? -{hi_n_c, lo_n_c} : {hi_n_c, lo_n_c};
    quot_c = neg_res ? -lo_n_c : lo_n_c;
    rem_c  = neg_rem ? -hi_n_c : hi_n_c;
    case (func)
      3'b000:                 result_c = prod_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_c = prod_c[PW-1:XLEN];
      3'b100, 3'b101:         result_c = quot_c;
      default:                result_c = rem_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cnt     <= '0;
      func    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.StartE) begin
            func    <= bus.MulDivFuncE;
            cnt     <= '0;
            neg_res <= a_neg_c ^ b_neg_c;
            neg_rem <= a_neg_c;
            hi      <= '0;
            lo      <= req_div_c ? mag_a_c : mag_b_c;
            opnd    <= req_div_c ? mag_b_c : mag_a_c;
            if (div_zero_c || div_ovf_c) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              if (div_zero_c) result <= bus.MulDivFuncE[1] ? bus.OpA : '1;
              else            result <= bus.MulDivFuncE[1] ? '0 : MIN_NEG;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          hi  <= hi_n_c;
          lo  <= lo_n_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == '1) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= result_c;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy   = busy;
  assign bus.Done   = done;
  assign bus.Result = result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, handshake corner sequences,
// and random operations against an arithmetic reference model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(7))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // Reference: plain 64-bit arithmetic following the RV32M rules
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'd0, a});
    longint      ub = longint'({32'd0, b});
    logic [63:0] p;
    bit          ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f)
      3'b000: begin p = 64'(sa * sb); return p[31:0];  end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = 64'(ua * ub); return p[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'(sa / sb);
      3'b101: return (b == 0) ? 32'hFFFFFFFF : 32'(ua / ub);
      3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  task automatic scramble();
    bus.MulDivFuncE = 3'($urandom_range(7));
    bus.OpA         = $urandom;
    bus.OpB         = $urandom;
  endtask

  // Called at cycle 1 (just after the accept edge); waits for Done, counting Busy cycles
  task automatic wait_done(input bit hold, output int lat, output int busy_cnt);
    bus.StartE = hold;
    scramble();
    lat      = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      busy_cnt += int'(bus.Busy);
      if (bus.Done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
      scramble();
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output logic [31:0] res, output int lat,
                        output int busy_cnt);
    bus.StartE      = 1'b1;
    bus.MulDivFuncE = f;
    bus.OpA         = a;
    bus.OpB         = b;
    @(posedge clk); #1;
    wait_done(hold, lat, busy_cnt);
    res = bus.Result;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          bcnt;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_lat;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[3]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[4]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[5]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[6]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[7]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[8]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[9]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[10] = '{3'b111, 32'd5,        32'd0,        32'd5,        1};
    vecs[11] = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    vecs[12] = '{3'b100, 32'd7,        32'd0,        32'hFFFFFFFF, 1};

    reset           = 1'b1;
    bus.StartE      = 1'b1;
    bus.MulDivFuncE = 3'b000;
    bus.OpA         = 32'd3;
    bus.OpB         = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   bus.Busy,   1'b0);
    check("reset_done",   bus.Done,   1'b0);
    check("reset_result", bus.Result, 32'h0);
    bus.StartE = 1'b0;
    reset      = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].func, vecs[i].a, vecs[i].b, 1'b0, res, lat, bcnt);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, (vecs[i].lat == 33) ? 32 : 0);
    end

    // StartE held with changing operands during RUN, then back-to-back accept from DONE
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 1'b1, res, lat, bcnt);
    check("hold_result",  res, 32'hFFFFFFEB);
    check("hold_latency", lat, 33);
    bus.StartE      = 1'b1;
    bus.MulDivFuncE = 3'b101;
    bus.OpA         = 32'd100;
    bus.OpB         = 32'd7;
    @(posedge clk); #1;
    check("b2b_busy_next", bus.Busy, 1'b1);
    check("b2b_done_next", bus.Done, 1'b0);
    wait_done(1'b0, lat, bcnt);
    check("b2b_result",  bus.Result, 32'd14);
    check("b2b_latency", lat, 33);

    // Reset at RUN cycle 10 abandons the op; first post-reset request runs normally
    bus.StartE      = 1'b1;
    bus.MulDivFuncE = 3'b000;
    bus.OpA         = 32'd7;
    bus.OpB         = 32'hFFFFFFFD;
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("rst_run_busy_before", bus.Busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_run_busy",   bus.Busy,   1'b0);
    check("rst_run_done",   bus.Done,   1'b0);
    check("rst_run_result", bus.Result, 32'h0);
    reset = 1'b0;
    run_op(3'b101, 32'd100, 32'd7, 1'b0, res, lat, bcnt);
    check("post_rst_result",  res, 32'd14);
    check("post_rst_latency", lat, 33);
    check("post_rst_busy",    bcnt, 32);

    for (int i = 0; i < 250; i++) begin
      f = 3'($urandom_range(7));
      a = pick_operand();
      b = pick_operand();
      exp_lat = ref_latency(f, a, b);
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
      run_op(f, a, b, 1'b0, res, lat, bcnt);
      check($sformatf("rnd%0d_f%0d_%h_%h_result", i, f, a, b), res, ref_result(f, a, b));
      check($sformatf("rnd%0d_latency", i), lat, exp_lat);
      check($sformatf("rnd%0d_busy_cycles", i), bcnt, (exp_lat == 33) ? 32 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
